// File: rtl/assist_pkg.sv
// Shared types and widths for the assist motor-control blocks (driver, telemetry, probes).
package assist_pkg;

  localparam int unsigned ASSIST_W = 13;
  localparam int unsigned DUTY_W   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    HOLD  = 2'd2,
    BRAKE = 2'd3
  } drv_state_t;

endpackage

// File: rtl/assist_pwm_driver_if.sv
// Bundle between the assistance calculator / half-bridge side and the PWM driver.
interface assist_pwm_driver_if;

  logic [assist_pkg::ASSIST_W-1:0] assist_req;
  logic                            brake;
  logic                            pwm_out;
  logic [assist_pkg::DUTY_W-1:0]   duty;
  logic                            period_stb;
  assist_pkg::drv_state_t          drv_state;

  modport master (
    output assist_req, brake,
    input  pwm_out, duty, period_stb, drv_state
  );

  modport slave (
    input  assist_req, brake,
    output pwm_out, duty, period_stb, drv_state
  );

endinterface

// File: rtl/assist_slew_limiter.sv
// Combinational next-duty: steps duty toward tgt by at most RAMP_UP / RAMP_DOWN counts.
module assist_slew_limiter
  import assist_pkg::*;
#(
  parameter int unsigned RAMP_UP   = 8,
  parameter int unsigned RAMP_DOWN = 64
) (
  input  logic [DUTY_W-1:0] duty,
  input  logic [DUTY_W-1:0] tgt,
  output logic [DUTY_W-1:0] duty_nxt
);

  localparam int unsigned SW = DUTY_W + 1;

  logic [SW-1:0] d, t, diff, step;

  // One spare bit keeps the difference exact, so the step never overshoots tgt or wraps below 0.
  always_comb begin
    d        = {1'b0, duty};
    t        = {1'b0, tgt};
    diff     = '0;
    step     = '0;
    duty_nxt = duty;
    if (t > d) begin
      diff     = t - d;
      step     = (diff > SW'(RAMP_UP)) ? SW'(RAMP_UP) : diff;
      duty_nxt = DUTY_W'(d + step);
    end else if (t < d) begin
      diff     = d - t;
      step     = (diff > SW'(RAMP_DOWN)) ? SW'(RAMP_DOWN) : diff;
      duty_nxt = DUTY_W'(d - step);
    end
  end

endmodule

// File: rtl/assist_pwm_driver.sv
// Assist motor PWM driver: period counter, slew-limited duty, brake shutdown with re-arm holdoff.
// Optional ASSIST_FILTER_EN: target is the mean of the last 4 sampled targets.
module assist_pwm_driver
  import assist_pkg::*;
#(
  parameter int unsigned PWM_PERIOD  = 2500,
  parameter int unsigned RAMP_UP     = 8,
  parameter int unsigned RAMP_DOWN   = 64,
  parameter int unsigned HOLDOFF_PER = 200
) (
  input  logic                clk,
  input  logic                rst,
  assist_pwm_driver_if.slave  bus
);

  localparam logic [DUTY_W-1:0] PERIOD_C  = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] LAST_C    = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [15:0]       HOLD_LAST = 16'(HOLDOFF_PER - 1);

  logic [DUTY_W-1:0]          cnt, cnt_nxt;
  logic [DUTY_W-1:0]          duty_q, duty_nxt, duty_slew;
  logic [DUTY_W-1:0]          tgt_raw, tgt;
  logic [ASSIST_W+DUTY_W-1:0] prod;
  logic                       boundary;
  logic                       brake_m, brake_s;
  logic                       pwm_q, stb_q;
  logic [15:0]                hold_cnt;
  drv_state_t                 state;

  always_comb begin
    boundary = (cnt == LAST_C);
    cnt_nxt  = boundary ? '0 : cnt + 1'b1;
    prod     = {{DUTY_W{1'b0}}, bus.assist_req} * {{ASSIST_W{1'b0}}, PERIOD_C};
    tgt_raw  = DUTY_W'(prod >> ASSIST_W);
    duty_nxt = (boundary && state != BRAKE) ? duty_slew : duty_q;
  end

`ifdef ASSIST_FILTER_EN
  logic [DUTY_W-1:0] hist [3];
  logic [DUTY_W+1:0] fsum;

  // The freshly sampled target counts as the newest of the four averaged values.
  always_comb begin
    fsum = {2'b00, tgt_raw} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    tgt  = DUTY_W'(fsum >> 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '{default: '0};
    end else if (brake_s) begin
      hist <= '{default: '0};
    end else if (boundary && state != BRAKE) begin
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= tgt_raw;
    end
  end
`else
  always_comb tgt = tgt_raw;
`endif

  assist_slew_limiter #(
    .RAMP_UP   (RAMP_UP),
    .RAMP_DOWN (RAMP_DOWN)
  ) u_slew (
    .duty     (duty_q),
    .tgt      (tgt),
    .duty_nxt (duty_slew)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      brake_m  <= 1'b0;
      brake_s  <= 1'b0;
      stb_q    <= 1'b0;
      pwm_q    <= 1'b0;
      duty_q   <= '0;
      hold_cnt <= '0;
      state    <= IDLE;
    end else begin
      brake_m <= bus.brake;
      brake_s <= brake_m;
      cnt     <= cnt_nxt;
      stb_q   <= boundary;
      if (brake_s) begin
        // Brake wins over any boundary update on the same cycle.
        state    <= BRAKE;
        duty_q   <= '0;
        hold_cnt <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (state == BRAKE) begin
          if (stb_q) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= IDLE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
        end else if (boundary) begin
          duty_q <= duty_slew;
          if (duty_slew != tgt)      state <= RAMP;
          else if (duty_slew == '0)  state <= IDLE;
          else                       state <= HOLD;
        end
        pwm_q <= (state != BRAKE) && (cnt_nxt < duty_nxt);
      end
    end
  end

  assign bus.pwm_out    = pwm_q;
  assign bus.duty       = duty_q;
  assign bus.period_stb = stb_q;
  assign bus.drv_state  = state;

endmodule
